// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read handshake, MEM-stage redirect,
// and the registered instruction triple handed to decode.
interface fetch_if;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_inst;
  logic [15:0] if_pc;
  logic [15:0] if_pc_next;

  modport master (
    output imem_read, imem_address, if_valid, if_inst, if_pc, if_pc_next,
    input  imem_resp, imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_read, imem_address, if_valid, if_inst, if_pc, if_pc_next,
    output imem_resp, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: PC, imem read handshake, one-entry skid buffer, redirect squash.
// Optional FETCH_PERF_EN adds saturating accepted/stalled cycle counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {RUN, FULL, SQUASH} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_squash_addr;
  logic [15:0] r_buf_inst;
  logic [15:0] r_buf_pc;
  logic        r_valid;
  logic [15:0] r_inst;
  logic [15:0] r_if_pc;
  logic [15:0] r_if_pc_next;

  logic [15:0] w_pc_inc;
  logic [15:0] w_redirect_pc;
  logic        w_load;

  assign w_pc_inc      = r_pc + 16'd2;
  assign w_redirect_pc = bus.redirect_pc & 16'hFFFE;
  assign w_load        = !r_valid || !bus.stall;

  // SQUASH keeps presenting the abandoned address until its response retires it
  assign bus.imem_read    = reset_n && (r_state != FULL);
  assign bus.imem_address = (r_state == SQUASH) ? r_squash_addr : r_pc;

  assign bus.if_valid   = r_valid;
  assign bus.if_inst    = r_inst;
  assign bus.if_pc      = r_if_pc;
  assign bus.if_pc_next = r_if_pc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_squash_addr <= 16'h0000;
      r_buf_inst    <= 16'h0000;
      r_buf_pc      <= 16'h0000;
      r_valid       <= 1'b0;
      r_inst        <= 16'h0000;
      r_if_pc       <= 16'h0000;
      r_if_pc_next  <= 16'h0000;
    end else if (bus.redirect) begin
      r_valid    <= 1'b0;
      r_buf_inst <= 16'h0000;
      r_buf_pc   <= 16'h0000;
      r_pc       <= w_redirect_pc;
      case (r_state)
        RUN: begin
          if (!bus.imem_resp) begin
            r_squash_addr <= r_pc;
            r_state       <= SQUASH;
          end
        end
        FULL:    r_state <= RUN;
        default: r_state <= r_state;
      endcase
    end else begin
      case (r_state)
        RUN: begin
          if (bus.imem_resp) begin
            r_pc <= w_pc_inc;
            if (w_load) begin
              r_inst       <= bus.imem_rdata;
              r_if_pc      <= r_pc;
              r_if_pc_next <= w_pc_inc;
              r_valid      <= 1'b1;
            end else begin
              r_buf_inst <= bus.imem_rdata;
              r_buf_pc   <= r_pc;
              r_state    <= FULL;
            end
          end else if (!bus.stall) begin
            r_valid <= 1'b0;
          end
        end
        FULL: begin
          if (!bus.stall) begin
            r_inst       <= r_buf_inst;
            r_if_pc      <= r_buf_pc;
            r_if_pc_next <= r_buf_pc + 16'd2;
            r_valid      <= 1'b1;
            r_state      <= RUN;
          end
        end
        SQUASH: begin
          if (bus.imem_resp) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else if (r_valid) begin
      if (!bus.stall) begin
        if (r_fetch_count != 32'hFFFF_FFFF) r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        if (r_stall_count != 32'hFFFF_FFFF) r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/latency traffic
// checked against a queue-based model of the fetch stream.
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  logic clk;
  logic reset_n;
  fetch_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: instructions visible to decode (head) plus any buffered word, in order
  ent_t        q[$];
  logic [15:0] m_pc;
  logic [15:0] m_sq_addr;
  bit          m_sq;
  int          lat;
  int          wait_cnt;
  int unsigned m_fc;
  int unsigned m_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc      = 16'h0000;
    m_sq      = 1'b0;
    m_sq_addr = 16'h0000;
    wait_cnt  = lat;
    m_fc      = 0;
    m_sc      = 0;
  endtask

  task automatic cmp();
    bit exp_read;
    exp_read = (q.size() < 2);
    chk("imem_read", {31'd0, bus.imem_read}, {31'd0, exp_read});
    if (exp_read) chk("imem_address", {16'd0, bus.imem_address}, {16'd0, (m_sq ? m_sq_addr : m_pc)});
    chk("if_valid", {31'd0, bus.if_valid}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      chk("if_inst", {16'd0, bus.if_inst}, {16'd0, q[0].inst});
      chk("if_pc", {16'd0, bus.if_pc}, {16'd0, q[0].pc});
      chk("if_pc_next", {16'd0, bus.if_pc_next}, {16'd0, q[0].pc + 16'd2});
    end
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, m_fc);
    chk("stall_count", stall_count, m_sc);
`endif
  endtask

  task automatic model_update(input bit s, input bit rd, input logic [15:0] rpc,
                              input bit resp, input logic [15:0] rdata);
    ent_t e;
    if (q.size() > 0) begin
      if (!s) m_fc++;
      else    m_sc++;
    end
    if (rd) begin
      if (!m_sq && q.size() < 2 && !resp) begin
        m_sq      = 1'b1;
        m_sq_addr = m_pc;
      end
      q.delete();
      m_pc = rpc & 16'hFFFE;
    end else if (m_sq) begin
      if (resp) m_sq = 1'b0;
    end else begin
      if (q.size() > 0 && !s) void'(q.pop_front());
      if (resp) begin
        e.inst = rdata;
        e.pc   = m_pc;
        q.push_back(e);
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  // Called at a negative edge; applies one cycle of inputs and checks the result.
  task automatic step(input bit s, input bit rd, input logic [15:0] rpc);
    bit          read_now;
    bit          resp;
    logic [15:0] rdata;
    read_now = (q.size() < 2);
    resp     = read_now && (wait_cnt == 0);
    rdata    = 16'($urandom);
    bus.stall       = s;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_resp   = resp;
    bus.imem_rdata  = rdata;
    @(posedge clk);
    model_update(s, rd, rpc, resp, rdata);
    if (resp) wait_cnt = lat;
    else if (read_now && wait_cnt > 0) wait_cnt--;
    #1;
    bus.imem_resp = 1'b0;
    bus.redirect  = 1'b0;
    @(negedge clk);
    cmp();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.imem_resp = 1'b0;
    #1;
    chk("rst_imem_read", {31'd0, bus.imem_read}, 32'd0);
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_if_inst", {16'd0, bus.if_inst}, 32'd0);
    chk("rst_if_pc", {16'd0, bus.if_pc}, 32'd0);
    chk("rst_if_pc_next", {16'd0, bus.if_pc_next}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
`endif
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    #1;
    cmp();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
    bus.imem_resp = 1'b0; bus.imem_rdata = 16'h0000;
    lat = 0;
    #1;
    chk("init_imem_read", {31'd0, bus.imem_read}, 32'd0);
    chk("init_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("init_if_pc", {16'd0, bus.if_pc}, 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    #1;
    cmp();
    chk("first_addr", {16'd0, bus.imem_address}, 32'h0000);

    // sequential stream then back-pressure with skid
    step(0, 0, 0); chk("seq_pc0", {16'd0, bus.if_pc}, 32'h0000);
    step(0, 0, 0); chk("seq_pc2", {16'd0, bus.if_pc}, 32'h0002);
    step(1, 0, 0); chk("full_read", {31'd0, bus.imem_read}, 32'd0);
    chk("full_pc_hold", {16'd0, bus.if_pc}, 32'h0002);
    step(1, 0, 0);
    step(1, 0, 0); chk("full_pc_hold3", {16'd0, bus.if_pc}, 32'h0002);
    step(0, 0, 0); chk("drain_pc4", {16'd0, bus.if_pc}, 32'h0004);
    step(0, 0, 0); chk("after_pc6", {16'd0, bus.if_pc}, 32'h0006);

    // redirect coinciding with a response, then redirect over a slow read
    lat = 2;
    step(0, 1, 16'h0010);
    chk("same_cyc_addr", {16'd0, bus.imem_address}, 32'h0010);
    chk("same_cyc_valid", {31'd0, bus.if_valid}, 32'd0);
    step(0, 1, 16'h0100);
    chk("squash_addr", {16'd0, bus.imem_address}, 32'h0010);
    step(0, 0, 0);
    chk("squash_addr2", {16'd0, bus.imem_address}, 32'h0010);
    step(0, 0, 0);
    chk("post_squash_addr", {16'd0, bus.imem_address}, 32'h0100);
    chk("post_squash_valid", {31'd0, bus.if_valid}, 32'd0);
    lat = 0; wait_cnt = 0;
    step(0, 0, 0); chk("target_pc", {16'd0, bus.if_pc}, 32'h0100);

    // odd redirect target and PC wrap
    step(0, 1, 16'hFFFF);
    chk("wrap_addr", {16'd0, bus.imem_address}, 32'hFFFE);
    step(0, 0, 0); chk("wrap_pc", {16'd0, bus.if_pc}, 32'hFFFE);
    chk("wrap_pc_next", {16'd0, bus.if_pc_next}, 32'h0000);
    step(0, 0, 0); chk("wrapped_pc", {16'd0, bus.if_pc}, 32'h0000);

    // reset asserted while squashing
    lat = 3; wait_cnt = 3;
    step(0, 1, 16'h0200);
    chk("sq_before_rst", {16'd0, bus.imem_address}, 32'h0002);
    lat = 0;
    do_reset();
    chk("restart_addr", {16'd0, bus.imem_address}, 32'h0000);

`ifdef FETCH_PERF_EN
    step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    chk("perf_fetch10", fetch_count, 32'd10);
    chk("perf_stall4", stall_count, 32'd4);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, 16'($urandom));
      if (i % 1000 == 999) begin
        lat = $urandom_range(0, 3);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
